// File: rtl/fetch_queue_pkg.sv
// Shared CPU constants for the fetch queue: default geometry and the NOP word.
package fetch_queue_pkg;
   localparam int          FQ_DEPTH = 4;
   localparam int          FQ_WIDTH = 32;
   localparam logic [31:0] FQ_NOP   = 32'h0000_0000;

   function automatic bit is_pow2(input int n);
      return (n >= 2) && ((n & (n - 1)) == 0);
   endfunction
endpackage

// File: rtl/fetch_queue_if.sv
// Enqueue/dequeue handshake bundle between the fetch stage and the IF/ID register.
interface fetch_queue_if #(
   parameter int WIDTH = fetch_queue_pkg::FQ_WIDTH
);
   logic             enq_valid_i;
   logic [WIDTH-1:0] enq_pc4_i;
   logic [WIDTH-1:0] enq_instr_i;
   logic             enq_ready_o;
   logic             deq_ready_i;
   logic             deq_valid_o;
   logic [WIDTH-1:0] deq_pc4_o;
   logic [WIDTH-1:0] deq_instr_o;

   modport slave (
      input  enq_valid_i, enq_pc4_i, enq_instr_i, deq_ready_i,
      output enq_ready_o, deq_valid_o, deq_pc4_o, deq_instr_o
   );

   modport master (
      output enq_valid_i, enq_pc4_i, enq_instr_i, deq_ready_i,
      input  enq_ready_o, deq_valid_o, deq_pc4_o, deq_instr_o
   );
endinterface

// File: rtl/fetch_queue_storage.sv
// Fetch queue entry RAM: one synchronous write port, one asynchronous read port.
// Contents are deliberately unreset; the queue masks them while empty.
module fq_storage #(
   parameter int DEPTH = 4,
   parameter int DW    = 64,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          clk_i,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_dat,
   input  logic [AW-1:0] rd_addr,
   output logic [DW-1:0] rd_dat
);
   logic [DW-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_dat;
      end
   end

   assign rd_dat = mem[rd_addr];
endmodule

// File: rtl/fetch_queue.sv
// Show-ahead instruction fetch queue: push visible at the head one cycle later.
// enq_ready_o depends only on the registered count, so a full queue refuses pushes even when popping.
module fetch_queue
   import fetch_queue_pkg::*;
#(
   parameter int DEPTH = FQ_DEPTH,
   parameter int WIDTH = FQ_WIDTH
) (
   input  logic                     clk_i,
   input  logic                     rst_i,
   input  logic                     flush_i,
   fetch_queue_if.slave             q,
   output logic [$clog2(DEPTH):0]   count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   if (!is_pow2(DEPTH)) begin : g_bad_depth
      $error("fetch_queue: DEPTH must be a power of two, at least 2");
   end

   logic [AW-1:0]      wr_ptr_q;
   logic [AW-1:0]      rd_ptr_q;
   logic [CW-1:0]      count_q;
   logic               not_empty;
   logic               push;
   logic               pop;
   logic [2*WIDTH-1:0] head_dat;

   assign not_empty     = (count_q != '0);
   assign q.enq_ready_o = (count_q < CW'(DEPTH));
   assign push          = q.enq_valid_i && q.enq_ready_o && !flush_i;
   assign pop           = not_empty && q.deq_ready_i && !flush_i;

   always_ff @(posedge clk_i) begin
      if (rst_i || flush_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
         count_q <= count_q + CW'(push) - CW'(pop);
      end
   end

   fq_storage #(
      .DEPTH (DEPTH),
      .DW    (2 * WIDTH),
      .AW    (AW)
   ) u_storage (
      .clk_i   (clk_i),
      .wr_en   (push),
      .wr_addr (wr_ptr_q),
      .wr_dat  ({q.enq_pc4_i, q.enq_instr_i}),
      .rd_addr (rd_ptr_q),
      .rd_dat  (head_dat)
   );

   // Stale RAM contents must never leak out while the queue is empty.
   assign q.deq_valid_o = not_empty;
   assign q.deq_pc4_o   = not_empty ? head_dat[2*WIDTH-1:WIDTH] : '0;
   assign q.deq_instr_o = not_empty ? head_dat[WIDTH-1:0] : WIDTH'(FQ_NOP);
   assign count_o       = count_q;
endmodule
